// File: rtl/mem_data_bridge.sv
`timescale 1ns/1ps
// mem_data_bridge
//   Sits between the EX/MEM pipeline register and the data-side SRAM-like bus.
//   Each load or store issues exactly one req/addr_ok/data_ok transaction. The
//   pipeline is frozen (stallM) while that transaction is outstanding. A load's
//   raw 32-bit read word is captured in RAMtmp for the MEM stage. The MEM stage
//   lane-selects and extends that word itself.
//
//   Optional build macro: MEM_DATA_BRIDGE_ADDR_ERR_EN
//     When defined, the block adds output addr_errM. A misaligned half or word
//     access then raises addr_errM and is never issued to the bus.
//
// Ports
//   clk, rst            clock; synchronous active-low reset
//   MemReadM/MemWriteM  load / store currently in MEM
//   MemReadType[2:0]    [1:0] size (00 byte, 01 half, 10 word); [2] sign is unused here
//   ALUout              byte address
//   WriteDataM          right-aligned store data
//   flushM              kill the MEM instruction (exception / eret)
//   stall_other         pipeline held by another stage
//   data_*              SRAM-like data bus (req/wr/size/addr/wdata/wstrb, addr_ok/data_ok/rdata)
//   RAMtmp              captured read word (byte lane 0 sits in [31:24])
//   stallM              freeze IF..MEM
//   addr_errM           (macro only) misaligned access detected
module mem_data_bridge #(
  parameter logic [31:0] RESET_RAMTMP    = 32'h0000_0000,
  parameter int          MAX_OUTSTANDING = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        MemReadM,
  input  logic        MemWriteM,
  input  logic [2:0]  MemReadType,
  input  logic [31:0] ALUout,
  input  logic [31:0] WriteDataM,
  input  logic        flushM,
  input  logic        stall_other,
  output logic        data_req,
  output logic        data_wr,
  output logic [1:0]  data_size,
  output logic [31:0] data_addr,
  output logic [31:0] data_wdata,
  output logic [3:0]  data_wstrb,
  input  logic        data_addr_ok,
  input  logic        data_data_ok,
  input  logic [31:0] data_rdata,
  output logic [31:0] RAMtmp,
`ifdef MEM_DATA_BRIDGE_ADDR_ERR_EN
  output logic        addr_errM,
`endif
  output logic        stallM
);

  // Only a single outstanding transaction is supported.
  generate
    if (MAX_OUTSTANDING != 1) begin : gBadCfg
      $error("mem_data_bridge: MAX_OUTSTANDING must be 1");
    end
  endgenerate

  localparam logic [2:0] IDLE = 3'd0;
  localparam logic [2:0] REQ  = 3'd1;
  localparam logic [2:0] WAIT = 3'd2;
  localparam logic [2:0] DONE = 3'd3;
  localparam logic [2:0] DROP = 3'd4;

  logic [2:0] state, nextState;
  logic       access, issue, addrErr, capture;
  logic [1:0] sizeSel, offs;

  assign sizeSel = MemReadType[1:0];
  assign offs    = ALUout[1:0];
  assign access  = (MemReadM | MemWriteM) & ~flushM;

  // The sign bit only matters to the MEM-stage extender.
  logic unusedSign;
  assign unusedSign = MemReadType[2];

`ifdef MEM_DATA_BRIDGE_ADDR_ERR_EN
  logic misalign;
  assign misalign  = ((sizeSel == 2'b01) & offs[0]) |
                     ((sizeSel == 2'b10) & (offs != 2'b00));
  assign addrErr   = access & misalign;
  assign addr_errM = addrErr;
`else
  assign addrErr   = 1'b0;
`endif

  // A faulting access never starts a bus transaction.
  assign issue = access & ~addrErr;

  // Next-state logic. capture fires only on the cycle when load data is
  // accepted for an instruction that was not flushed.
  always_comb begin
    nextState = state;
    capture   = 1'b0;
    case (state)
      IDLE: begin
        if (issue) nextState = REQ;
      end
      REQ: begin
        if (data_addr_ok) begin
          if (flushM) begin
            // The request is already accepted; its response must be drained.
            nextState = data_data_ok ? IDLE : DROP;
          end else if (data_data_ok) begin
            nextState = DONE;
            capture   = MemReadM;
          end else begin
            nextState = WAIT;
          end
        end else if (flushM) begin
          nextState = IDLE;
        end
      end
      WAIT: begin
        if (flushM) begin
          nextState = data_data_ok ? IDLE : DROP;
        end else if (data_data_ok) begin
          nextState = DONE;
          capture   = MemReadM;
        end
      end
      DROP: begin
        if (data_data_ok) nextState = IDLE;
      end
      DONE: begin
        // Hold here while the pipeline is frozen elsewhere. The same
        // instruction is still in MEM and must not be re-issued.
        if (flushM)           nextState = IDLE;
        else if (!stall_other) nextState = IDLE;
      end
      default: nextState = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state  <= IDLE;
      RAMtmp <= RESET_RAMTMP;
    end else begin
      state <= nextState;
      if (capture) RAMtmp <= data_rdata;
    end
  end

  // The bus fields come straight from the MEM inputs. Those inputs are held
  // by stallM, so they stay stable until addr_ok.
  assign data_req  = (state == REQ);
  assign data_wr   = MemWriteM;
  assign data_size = sizeSel;
  assign data_addr = ALUout;

  // Lane replication for sub-word stores.
  always_comb begin
    case (sizeSel)
      2'b00:   data_wdata = {4{WriteDataM[7:0]}};
      2'b01:   data_wdata = {2{WriteDataM[15:0]}};
      default: data_wdata = WriteDataM;
    endcase
  end

  // Byte lane 0 (offset 00) maps to strobe bit 3 / data[31:24].
  always_comb begin
    data_wstrb = 4'b0000;
    if (MemWriteM) begin
      case (sizeSel)
        2'b00:   data_wstrb = 4'b1000 >> offs;
        2'b01:   data_wstrb = offs[1] ? 4'b0011 : 4'b1100;
        default: data_wstrb = 4'b1111;
      endcase
    end
  end

  assign stallM = (state == REQ) | (state == WAIT) | (state == DROP) |
                  ((state == IDLE) & issue);

endmodule

// File: tb/tb_mem_data_bridge.sv
`timescale 1ns/1ps
module tb_mem_data_bridge;

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_WAIT = 3'd2;
  localparam logic [2:0] S_DONE = 3'd3;
  localparam logic [2:0] S_DROP = 3'd4;

  logic        clk = 1'b0;
  logic        rst;
  logic        MemReadM, MemWriteM;
  logic [2:0]  MemReadType;
  logic [31:0] ALUout, WriteDataM;
  logic        flushM, stall_other;
  logic        data_req, data_wr;
  logic [1:0]  data_size;
  logic [31:0] data_addr, data_wdata;
  logic [3:0]  data_wstrb;
  logic        data_addr_ok, data_data_ok;
  logic [31:0] data_rdata;
  logic [31:0] RAMtmp;
  logic        stallM;
`ifdef MEM_DATA_BRIDGE_ADDR_ERR_EN
  logic        addr_errM;
`endif

  int total = 0;
  int bad   = 0;
  logic [31:0] expRam;
  int stallCnt, reqCnt;

  always #5 clk = ~clk;

  mem_data_bridge dut (
    .clk(clk), .rst(rst),
    .MemReadM(MemReadM), .MemWriteM(MemWriteM), .MemReadType(MemReadType),
    .ALUout(ALUout), .WriteDataM(WriteDataM), .flushM(flushM),
    .stall_other(stall_other),
    .data_req(data_req), .data_wr(data_wr), .data_size(data_size),
    .data_addr(data_addr), .data_wdata(data_wdata), .data_wstrb(data_wstrb),
    .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok),
    .data_rdata(data_rdata), .RAMtmp(RAMtmp),
`ifdef MEM_DATA_BRIDGE_ADDR_ERR_EN
    .addr_errM(addr_errM),
`endif
    .stallM(stallM)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Full store with addr_ok & data_ok in the first REQ cycle.
  task automatic storeChk(input string tag, input logic [31:0] addr, input logic [31:0] wd,
                          input logic [2:0] typ, input logic [3:0] expStrb,
                          input logic [31:0] expWd);
    MemWriteM = 1'b1; MemReadType = typ; ALUout = addr; WriteDataM = wd;
    tick();  // REQ
    data_addr_ok = 1'b1; data_data_ok = 1'b1; data_rdata = 32'hBAD0_BAD0;
    @(negedge clk);
    chk({tag, "_req"},   {31'd0, data_req},  32'd1);
    chk({tag, "_wr"},    {31'd0, data_wr},   32'd1);
    chk({tag, "_size"},  {30'd0, data_size}, {30'd0, typ[1:0]});
    chk({tag, "_strb"},  {28'd0, data_wstrb}, {28'd0, expStrb});
    chk({tag, "_wdata"}, data_wdata, expWd);
    tick();  // DONE
    data_addr_ok = 1'b0; data_data_ok = 1'b0; MemWriteM = 1'b0;
    @(negedge clk);
    chk({tag, "_stall"}, {31'd0, stallM}, 32'd0);
    chk({tag, "_ram"},   RAMtmp, expRam);
    tick();  // IDLE
  endtask

  initial begin
    #200000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1);
  end

  initial begin
    rst = 1'b0; MemReadM = 1'b0; MemWriteM = 1'b0; MemReadType = 3'b000;
    ALUout = 32'd0; WriteDataM = 32'd0; flushM = 1'b0; stall_other = 1'b0;
    data_addr_ok = 1'b0; data_data_ok = 1'b0; data_rdata = 32'd0;
    tick(); tick();
    @(negedge clk);
    chk("rst_req",   {31'd0, data_req}, 32'd0);
    chk("rst_stall", {31'd0, stallM},   32'd0);
    chk("rst_ram",   RAMtmp, 32'd0);
    chk("rst_state", {29'd0, dut.state}, {29'd0, S_IDLE});
    rst = 1'b1;
    tick();

    // LW 0x80000004, addr_ok & data_ok in the first REQ cycle.
    MemReadM = 1'b1; MemReadType = 3'b010; ALUout = 32'h8000_0004;
    @(negedge clk);
    chk("lw_idle_stall", {31'd0, stallM},   32'd1);
    chk("lw_idle_req",   {31'd0, data_req}, 32'd0);
    tick();
    data_addr_ok = 1'b1; data_data_ok = 1'b1; data_rdata = 32'h1122_3344;
    @(negedge clk);
    chk("lw_req",   {31'd0, data_req}, 32'd1);
    chk("lw_addr",  data_addr, 32'h8000_0004);
    chk("lw_size",  {30'd0, data_size}, 32'd2);
    chk("lw_wr",    {31'd0, data_wr}, 32'd0);
    chk("lw_strb",  {28'd0, data_wstrb}, 32'd0);
    chk("lw_stall", {31'd0, stallM}, 32'd1);
    tick();
    data_addr_ok = 1'b0; data_data_ok = 1'b0; data_rdata = 32'd0;
    @(negedge clk);
    chk("lw_done_stall", {31'd0, stallM}, 32'd0);
    chk("lw_done_req",   {31'd0, data_req}, 32'd0);
    chk("lw_ram",        RAMtmp, 32'h1122_3344);
    expRam = 32'h1122_3344;
    MemReadM = 1'b0;
    tick();
    @(negedge clk);
    chk("lw_back_idle", {29'd0, dut.state}, {29'd0, S_IDLE});

    // Stores: lane strobes and replication.
    storeChk("sb3", 32'h8000_0003, 32'h0000_00A5, 3'b000, 4'b0001, 32'hA5A5_A5A5);
    storeChk("sb0", 32'h8000_0000, 32'h0000_005A, 3'b000, 4'b1000, 32'h5A5A_5A5A);
    storeChk("sh2", 32'h8000_0002, 32'h1234_BEEF, 3'b001, 4'b0011, 32'hBEEF_BEEF);
    storeChk("sh0", 32'h8000_0000, 32'h1234_BEEF, 3'b001, 4'b1100, 32'hBEEF_BEEF);
    storeChk("sw",  32'h8000_0000, 32'hCAFE_1234, 3'b010, 4'b1111, 32'hCAFE_1234);

    // LH: addr_ok in the 2nd REQ cycle, data_ok 3 cycles after that.
    // cycle: 0 IDLE, 1-2 REQ, 3-5 WAIT, 6 DONE
    stallCnt = 0; reqCnt = 0;
    MemReadM = 1'b1; MemReadType = 3'b001; ALUout = 32'h8000_0006;
    for (int i = 0; i < 7; i++) begin
      data_addr_ok = (i == 2);
      data_data_ok = (i == 5);
      data_rdata   = (i == 5) ? 32'h8899_AABB : 32'h0;
      if (i == 6) MemReadM = 1'b0;
      @(negedge clk);
      if (stallM)   stallCnt++;
      if (data_req) begin
        reqCnt++;
        chk("lh_addr_stable", data_addr, 32'h8000_0006);
      end
      chk($sformatf("lh_req_c%0d", i), {31'd0, data_req}, {31'd0, (i == 1 || i == 2)});
      tick();
    end
    data_addr_ok = 1'b0; data_data_ok = 1'b0;
    chk("lh_stall_cycles", stallCnt, 32'd6);
    chk("lh_req_cycles",   reqCnt,   32'd2);
    chk("lh_ram",          RAMtmp,   32'h8899_AABB);
    expRam = 32'h8899_AABB;

    // Flush in WAIT, data_ok 2 cycles later is drained into DROP.
    MemReadM = 1'b1; MemReadType = 3'b010; ALUout = 32'h8000_0010;
    tick();                     // REQ
    data_addr_ok = 1'b1;
    tick();                     // WAIT
    data_addr_ok = 1'b0; flushM = 1'b1;
    @(negedge clk);
    chk("fl_wait_state", {29'd0, dut.state}, {29'd0, S_WAIT});
    tick();                     // DROP
    flushM = 1'b0; MemReadM = 1'b0;
    @(negedge clk);
    chk("fl_drop_state", {29'd0, dut.state}, {29'd0, S_DROP});
    chk("fl_drop_stall", {31'd0, stallM},   32'd1);
    chk("fl_drop_req",   {31'd0, data_req}, 32'd0);
    tick();
    data_data_ok = 1'b1; data_rdata = 32'hDEAD_BEEF;
    @(negedge clk);
    chk("fl_drop2_stall", {31'd0, stallM}, 32'd1);
    tick();
    data_data_ok = 1'b0; data_rdata = 32'd0;
    @(negedge clk);
    chk("fl_idle_state", {29'd0, dut.state}, {29'd0, S_IDLE});
    chk("fl_ram",        RAMtmp, expRam);
    chk("fl_idle_req",   {31'd0, data_req}, 32'd0);
    tick();
    @(negedge clk);
    chk("fl_no_reissue", {31'd0, data_req}, 32'd0);
    tick();

    // stall_other held for 3 cycles in DONE: one handshake only.
    reqCnt = 0;
    MemReadM = 1'b1; MemReadType = 3'b010; ALUout = 32'h8000_0008;
    tick();                     // REQ
    data_addr_ok = 1'b1; data_data_ok = 1'b1; data_rdata = 32'hCAFE_F00D;
    @(negedge clk);
    if (data_req) reqCnt++;
    tick();                     // DONE
    data_addr_ok = 1'b0; data_data_ok = 1'b0; data_rdata = 32'h0BAD_F00D;
    stall_other = 1'b1;
    for (int j = 0; j < 3; j++) begin
      @(negedge clk);
      if (data_req) reqCnt++;
      chk($sformatf("so_state_%0d", j), {29'd0, dut.state}, {29'd0, S_DONE});
      chk($sformatf("so_ram_%0d", j),   RAMtmp, 32'hCAFE_F00D);
      chk($sformatf("so_stall_%0d", j), {31'd0, stallM}, 32'd0);
      tick();
    end
    stall_other = 1'b0; MemReadM = 1'b0;
    @(negedge clk);
    if (data_req) reqCnt++;
    chk("so_last_done", {29'd0, dut.state}, {29'd0, S_DONE});
    tick();
    @(negedge clk);
    chk("so_idle",     {29'd0, dut.state}, {29'd0, S_IDLE});
    chk("so_handshk",  reqCnt, 32'd1);
    chk("so_ram_hold", RAMtmp, 32'hCAFE_F00D);

    // Reset while a transaction waits for data.
    MemReadM = 1'b1; MemReadType = 3'b010; ALUout = 32'h8000_0020;
    tick();                     // REQ
    data_addr_ok = 1'b1;
    tick();                     // WAIT
    data_addr_ok = 1'b0;
    @(negedge clk);
    chk("rw_wait", {29'd0, dut.state}, {29'd0, S_WAIT});
    rst = 1'b0; MemReadM = 1'b0;
    tick();
    rst = 1'b1;
    @(negedge clk);
    chk("rw_state", {29'd0, dut.state}, {29'd0, S_IDLE});
    chk("rw_ram",   RAMtmp, 32'd0);
    chk("rw_req",   {31'd0, data_req}, 32'd0);
    chk("rw_stall", {31'd0, stallM},   32'd0);
    tick();

`ifdef MEM_DATA_BRIDGE_ADDR_ERR_EN
    // Misaligned SW never issues.
    MemWriteM = 1'b1; MemReadType = 3'b010; ALUout = 32'h8000_0002;
    WriteDataM = 32'h1357_9BDF;
    @(negedge clk);
    chk("ae_err",   {31'd0, addr_errM}, 32'd1);
    chk("ae_stall", {31'd0, stallM},    32'd0);
    tick();
    @(negedge clk);
    chk("ae_req",   {31'd0, data_req},  32'd0);
    chk("ae_state", {29'd0, dut.state}, {29'd0, S_IDLE});
    ALUout = 32'h8000_0004;
    #1;
    chk("ae_aligned", {31'd0, addr_errM}, 32'd0);
    MemWriteM = 1'b0;
    tick();
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
